// File: rtl/ps2_pkg.sv
// ps2_pkg: shared types and helpers for the PS/2 mouse packet decoder.
//   frame_state_e  - frame receiver states
//   PS2_FRAME_BITS - start + 8 data + parity + stop
//   PKT_BYTES      - 3 (standard) or 4 (IntelliMouse, PS2_MOUSE_WHEEL_EN defined)
//   mouse_delta_t  - magnitude + sign of one movement axis
//   sat_mag()      - 9-bit two's complement delta -> saturated magnitude + sign
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

    localparam int unsigned PS2_FRAME_BITS = 11;

`ifdef PS2_MOUSE_WHEEL_EN
    localparam int unsigned PKT_BYTES = 4;
`else
    localparam int unsigned PKT_BYTES = 3;
`endif

    typedef struct packed {
        logic [7:0] mag;
        logic       neg;
    } mouse_delta_t;

    // -256 has no 8-bit magnitude and clamps to 255; the overflow flag forces 255 but keeps
    // the sign. A negative input can never yield a zero magnitude, so neg=0 for zero deltas.
    function automatic mouse_delta_t sat_mag(input logic [8:0] v, input logic ovf);
        mouse_delta_t d;
        logic [8:0]   abs_v;
        abs_v = v[8] ? (~v + 9'd1) : v;
        d.mag = (ovf || abs_v[8]) ? 8'hFF : abs_v[7:0];
        d.neg = v[8];
        return d;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronizes the raw PS/2 pins and receives 11-bit frames.
// Ports:
//   clk, arst_n     system clock, asynchronous active-low reset
//   i_ps2_clk/data  raw pad signals (asynchronous)
//   i_abort         force the frame FSM back to IDLE (timeout)
//   o_fall          one-cycle strobe on a synchronized ps2_clk falling edge
//   o_busy          frame in progress (FSM not IDLE)
//   o_byte          received byte (valid with o_byte_ok)
//   o_byte_ok       stop edge of a frame with good parity and stop bit
//   o_byte_err      stop edge of a frame with bad parity or stop bit
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    input  logic       i_abort,
    output logic       o_fall,
    output logic       o_busy,
    output logic [7:0] o_byte,
    output logic       o_byte_ok,
    output logic       o_byte_err
);

    localparam int unsigned DATA_BITS = PS2_FRAME_BITS - 3;

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;
    logic                   ps2_clk_s;
    logic                   ps2_data_s;

    frame_state_e state_q, state_d;
    logic [2:0]   bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d;
    logic         parity_q, parity_d;

    assign ps2_clk_s  = clk_sync_q[SYNC_STAGES-1];
    assign ps2_data_s = data_sync_q[SYNC_STAGES-1];
    assign o_fall     = clk_prev_q & ~ps2_clk_s;
    assign o_busy     = (state_q != IDLE);
    assign o_byte     = shift_q;

    // Synchronizers reset to 1 so an idle bus never looks like a falling edge after reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            clk_prev_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], i_ps2_data};
            clk_prev_q  <= ps2_clk_s;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= IDLE;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'd0;
            parity_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        o_byte_ok  = 1'b0;
        o_byte_err = 1'b0;
        if (i_abort) begin
            state_d = IDLE;
        end else if (o_fall) begin
            unique case (state_q)
                IDLE: begin
                    // A high data bit here is bus noise, not a start bit.
                    if (!ps2_data_s) begin
                        state_d   = DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
                DATA: begin
                    shift_d   = {ps2_data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
                        state_d = PARITY;
                    end
                end
                PARITY: begin
                    parity_d = ps2_data_s;
                    state_d  = STOP;
                end
                STOP: begin
                    if (ps2_data_s && (^{shift_q, parity_q})) begin
                        o_byte_ok = 1'b1;
                    end else begin
                        o_byte_err = 1'b1;
                    end
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ps2_mouse_packet_decoder.sv
// ps2_mouse_packet_decoder: assembles PS/2 mouse bytes into movement packets and converts
// them to saturated magnitude + sign deltas and a button vector.
// Ports:
//   clk, arst_n            system clock, asynchronous active-low reset
//   i_ps2_clk, i_ps2_data  raw PS/2 pad signals
//   o_valid                one-cycle pulse per decoded packet
//   o_mouse_dx/dy          |delta| saturated to 255, zero outside o_valid
//   o_is_mouse_dx/dy_neg   delta signs (dy after INVERT_Y), zero outside o_valid
//   o_buttons              {middle,right,left} of the last packet
//   o_err                  one-cycle pulse on frame error, resync drop or timeout
//   o_wheel                byte3[3:0] of the last packet (only with PS2_MOUSE_WHEEL_EN)
// Configuration macro: PS2_MOUSE_WHEEL_EN selects 4-byte IntelliMouse packets.
module ps2_mouse_packet_decoder
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter bit          INVERT_Y       = 1'b1
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_data,
    output logic       o_valid,
    output logic [7:0] o_mouse_dx,
    output logic [7:0] o_mouse_dy,
    output logic       o_is_mouse_dx_neg,
    output logic       o_is_mouse_dy_neg,
    output logic [2:0] o_buttons,
    output logic       o_err
`ifdef PS2_MOUSE_WHEEL_EN
    ,
    output logic [3:0] o_wheel
`endif
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    logic       fall;
    logic       busy;
    logic [7:0] rx_byte;
    logic       byte_ok;
    logic       byte_err;
    logic       tmo_hit;
    logic       active;

    logic [TW-1:0] tmo_q, tmo_d;
    logic [1:0]    idx_q, idx_d;
    logic [7:0]    b0_q, b0_d;
    logic [7:0]    b1_q, b1_d;
    logic [7:0]    b2_q, b2_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [7:0]    dx_q, dx_d;
    logic [7:0]    dy_q, dy_d;
    logic          dx_neg_q, dx_neg_d;
    logic          dy_neg_q, dy_neg_d;
    logic [2:0]    buttons_q, buttons_d;
`ifdef PS2_MOUSE_WHEEL_EN
    logic [3:0]    wheel_q, wheel_d;
`endif

    logic         finish;
    logic [7:0]   y_byte;
    mouse_delta_t dxv;
    mouse_delta_t dyv;

    ps2_frame_rx #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_frame_rx (
        .clk       (clk),
        .arst_n    (arst_n),
        .i_ps2_clk (i_ps2_clk),
        .i_ps2_data(i_ps2_data),
        .i_abort   (tmo_hit),
        .o_fall    (fall),
        .o_busy    (busy),
        .o_byte    (rx_byte),
        .o_byte_ok (byte_ok),
        .o_byte_err(byte_err)
    );

    // Stall watchdog: only runs while a frame or packet is partially received; it stops at
    // TIMEOUT_CYCLES so a single stall produces a single pulse.
    assign active  = busy || (idx_q != 2'd0);
    assign tmo_hit = active && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        tmo_d = tmo_q;
        if (fall) begin
            tmo_d = '0;
        end else if (active && (tmo_q != TW'(TIMEOUT_CYCLES))) begin
            tmo_d = tmo_q + TW'(1);
        end
    end

    always_comb begin
        idx_d     = idx_q;
        b0_d      = b0_q;
        b1_d      = b1_q;
        b2_d      = b2_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        dx_d      = 8'd0;
        dy_d      = 8'd0;
        dx_neg_d  = 1'b0;
        dy_neg_d  = 1'b0;
        buttons_d = buttons_q;
`ifdef PS2_MOUSE_WHEEL_EN
        wheel_d   = wheel_q;
`endif
        finish    = 1'b0;

        if (tmo_hit || byte_err) begin
            err_d = 1'b1;
            idx_d = 2'd0;
        end else if (byte_ok) begin
            if (idx_q == 2'd0) begin
                // Bit3 is always set in byte0; anything else means we lost packet alignment.
                if (rx_byte[3]) begin
                    b0_d  = rx_byte;
                    idx_d = 2'd1;
                end else begin
                    err_d = 1'b1;
                end
            end else if (idx_q == 2'd1) begin
                b1_d  = rx_byte;
                idx_d = 2'd2;
            end else if (idx_q == 2'(PKT_BYTES - 1)) begin
                finish = 1'b1;
                idx_d  = 2'd0;
            end else begin
                b2_d  = rx_byte;
                idx_d = idx_q + 2'd1;
            end
        end

        // In 3-byte mode the Y byte is the one arriving now; in 4-byte mode it was stored.
        y_byte = (idx_q == 2'd2) ? rx_byte : b2_q;
        dxv    = sat_mag({b0_q[4], b1_q}, b0_q[6]);
        dyv    = sat_mag({b0_q[5], y_byte}, b0_q[7]);

        if (finish) begin
            valid_d   = 1'b1;
            dx_d      = dxv.mag;
            dx_neg_d  = dxv.neg;
            dy_d      = dyv.mag;
            dy_neg_d  = dyv.neg ^ (INVERT_Y && (dyv.mag != 8'd0));
            buttons_d = b0_q[2:0];
`ifdef PS2_MOUSE_WHEEL_EN
            wheel_d   = rx_byte[3:0];
`endif
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            tmo_q     <= '0;
            idx_q     <= 2'd0;
            b0_q      <= 8'd0;
            b1_q      <= 8'd0;
            b2_q      <= 8'd0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            dx_q      <= 8'd0;
            dy_q      <= 8'd0;
            dx_neg_q  <= 1'b0;
            dy_neg_q  <= 1'b0;
            buttons_q <= 3'd0;
`ifdef PS2_MOUSE_WHEEL_EN
            wheel_q   <= 4'd0;
`endif
        end else begin
            tmo_q     <= tmo_d;
            idx_q     <= idx_d;
            b0_q      <= b0_d;
            b1_q      <= b1_d;
            b2_q      <= b2_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
            dx_neg_q  <= dx_neg_d;
            dy_neg_q  <= dy_neg_d;
            buttons_q <= buttons_d;
`ifdef PS2_MOUSE_WHEEL_EN
            wheel_q   <= wheel_d;
`endif
        end
    end

    assign o_valid           = valid_q;
    assign o_err             = err_q;
    assign o_mouse_dx        = dx_q;
    assign o_mouse_dy        = dy_q;
    assign o_is_mouse_dx_neg = dx_neg_q;
    assign o_is_mouse_dy_neg = dy_neg_q;
    assign o_buttons         = buttons_q;
`ifdef PS2_MOUSE_WHEEL_EN
    assign o_wheel           = wheel_q;
`endif

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Testbench for ps2_mouse_packet_decoder: drives PS/2 frames from the device side and checks
// decoded packets against an integer-arithmetic model of the delta rules.
module tb_ps2_mouse_packet_decoder;

    localparam int unsigned TMO = 2000;
    localparam bit          INV = 1'b1;

    logic       clk = 1'b0;
    logic       arst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       o_valid;
    logic [7:0] o_mouse_dx;
    logic [7:0] o_mouse_dy;
    logic       o_is_mouse_dx_neg;
    logic       o_is_mouse_dy_neg;
    logic [2:0] o_buttons;
    logic       o_err;
`ifdef PS2_MOUSE_WHEEL_EN
    logic [3:0] o_wheel;
`endif

    ps2_mouse_packet_decoder #(
        .SYNC_STAGES   (2),
        .TIMEOUT_CYCLES(TMO),
        .INVERT_Y      (INV)
    ) dut (
        .clk              (clk),
        .arst_n           (arst_n),
        .i_ps2_clk        (ps2_clk),
        .i_ps2_data       (ps2_data),
        .o_valid          (o_valid),
        .o_mouse_dx       (o_mouse_dx),
        .o_mouse_dy       (o_mouse_dy),
        .o_is_mouse_dx_neg(o_is_mouse_dx_neg),
        .o_is_mouse_dy_neg(o_is_mouse_dy_neg),
        .o_buttons        (o_buttons),
        .o_err            (o_err)
`ifdef PS2_MOUSE_WHEEL_EN
        ,
        .o_wheel          (o_wheel)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor: event counters and the last o_valid snapshot, sampled on the falling clk edge.
    int         valid_cnt = 0;
    int         err_cnt   = 0;
    int         idle_bad  = 0;
    int         both_bad  = 0;
    logic [7:0] cap_dx = 8'd0;
    logic [7:0] cap_dy = 8'd0;
    logic       cap_dxn = 1'b0;
    logic       cap_dyn = 1'b0;

    always @(negedge clk) begin
        if (o_valid) begin
            valid_cnt <= valid_cnt + 1;
            cap_dx    <= o_mouse_dx;
            cap_dy    <= o_mouse_dy;
            cap_dxn   <= o_is_mouse_dx_neg;
            cap_dyn   <= o_is_mouse_dy_neg;
        end else if (o_mouse_dx != 8'd0 || o_mouse_dy != 8'd0 || o_is_mouse_dx_neg
                     || o_is_mouse_dy_neg) begin
            idle_bad <= idle_bad + 1;
        end
        if (o_err) err_cnt <= err_cnt + 1;
        if (o_err && o_valid) both_bad <= both_bad + 1;
    end

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        #50;
        ps2_clk = 1'b0;
        #100;
        ps2_clk = 1'b1;
        #50;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par, input logic bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        #200;
    endtask

    // Axis model: interpret {sign,byte} as a signed integer and take its absolute value.
    task automatic model_axis(input logic [7:0] mv, input logic sign, input logic ovf,
                              output int mag, output logic neg);
        int v;
        v   = sign ? int'(mv) - 256 : int'(mv);
        mag = (v < 0) ? -v : v;
        if (mag > 255 || ovf) mag = 255;
        neg = (v < 0);
    endtask

    task automatic send_packet(input logic [7:0] p0, input logic [7:0] p1,
                               input logic [7:0] p2, input logic [7:0] p3, input string name);
        int   vc, ec, mx, my;
        logic nx, ny;
        vc = valid_cnt;
        ec = err_cnt;
        send_byte(p0, 1'b0, 1'b0);
        send_byte(p1, 1'b0, 1'b0);
        send_byte(p2, 1'b0, 1'b0);
`ifdef PS2_MOUSE_WHEEL_EN
        send_byte(p3, 1'b0, 1'b0);
`endif
        repeat (5) @(posedge clk);
        @(negedge clk);
        model_axis(p1, p0[4], p0[6], mx, nx);
        model_axis(p2, p0[5], p0[7], my, ny);
        if (INV && my != 0) ny = ~ny;
        n_checks++;
        if (valid_cnt - vc !== 1) begin
            n_fail++;
            $display("FAIL %s valid_pulses: got %0d want 1", name, valid_cnt - vc);
        end
        n_checks++;
        if (err_cnt - ec !== 0) begin
            n_fail++;
            $display("FAIL %s err_pulses: got %0d want 0", name, err_cnt - ec);
        end
        n_checks++;
        if ({cap_dxn, cap_dx} !== {nx, 8'(mx)}) begin
            n_fail++;
            $display("FAIL %s dx: got neg=%0d mag=%0d want neg=%0d mag=%0d",
                     name, cap_dxn, cap_dx, nx, mx);
        end
        n_checks++;
        if ({cap_dyn, cap_dy} !== {ny, 8'(my)}) begin
            n_fail++;
            $display("FAIL %s dy: got neg=%0d mag=%0d want neg=%0d mag=%0d",
                     name, cap_dyn, cap_dy, ny, my);
        end
        n_checks++;
        if (o_buttons !== p0[2:0]) begin
            n_fail++;
            $display("FAIL %s buttons: got %b want %b", name, o_buttons, p0[2:0]);
        end
`ifdef PS2_MOUSE_WHEEL_EN
        n_checks++;
        if (o_wheel !== p3[3:0]) begin
            n_fail++;
            $display("FAIL %s wheel: got %h want %h", name, o_wheel, p3[3:0]);
        end
`endif
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        #23;
        n_checks++;
        if ({o_valid, o_mouse_dx, o_mouse_dy, o_is_mouse_dx_neg, o_is_mouse_dy_neg,
             o_buttons, o_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got dx=%0d dy=%0d btn=%b v=%b e=%b want all 0",
                     o_mouse_dx, o_mouse_dy, o_buttons, o_valid, o_err);
        end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_known_packets();
        send_packet(8'h08, 8'h05, 8'hFB, 8'h01, "pkt_08_05_FB");
        send_packet(8'h19, 8'h00, 8'h10, 8'h0F, "pkt_19_00_10");
        send_packet(8'hCF, 8'h01, 8'h00, 8'h07, "pkt_ovf_both");
        send_packet(8'h38, 8'hFF, 8'h00, 8'h00, "pkt_neg1_neg256");
        send_packet(8'h08, 8'h00, 8'h00, 8'h00, "pkt_zero");
    endtask

    task automatic test_bad_parity();
        int vc, ec;
        vc = valid_cnt;
        ec = err_cnt;
        send_byte(8'h08, 1'b1, 1'b0);
        repeat (5) @(posedge clk);
        n_checks++;
        if (err_cnt - ec !== 1 || valid_cnt - vc !== 0) begin
            n_fail++;
            $display("FAIL bad_parity: got err=%0d valid=%0d want err=1 valid=0",
                     err_cnt - ec, valid_cnt - vc);
        end
        send_packet(8'h0A, 8'h20, 8'hE0, 8'h03, "after_bad_parity");
    endtask

    task automatic test_bad_stop();
        int vc, ec;
        vc = valid_cnt;
        ec = err_cnt;
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h33, 1'b0, 1'b1);
        repeat (5) @(posedge clk);
        n_checks++;
        if (err_cnt - ec !== 1 || valid_cnt - vc !== 0) begin
            n_fail++;
            $display("FAIL bad_stop: got err=%0d valid=%0d want err=1 valid=0",
                     err_cnt - ec, valid_cnt - vc);
        end
        send_packet(8'h0C, 8'h11, 8'h22, 8'h05, "after_bad_stop");
    endtask

    task automatic test_resync();
        int vc, ec;
        vc = valid_cnt;
        ec = err_cnt;
        send_byte(8'h00, 1'b0, 1'b0);
        repeat (5) @(posedge clk);
        n_checks++;
        if (err_cnt - ec !== 1 || valid_cnt - vc !== 0) begin
            n_fail++;
            $display("FAIL resync_drop: got err=%0d valid=%0d want err=1 valid=0",
                     err_cnt - ec, valid_cnt - vc);
        end
        send_packet(8'h08, 8'h01, 8'h01, 8'h02, "after_resync");
    endtask

    task automatic test_timeout();
        int vc, ec;
        vc = valid_cnt;
        ec = err_cnt;
        send_byte(8'h08, 1'b0, 1'b0);
        send_byte(8'h02, 1'b0, 1'b0);
        repeat (TMO + 10) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (err_cnt - ec !== 1 || valid_cnt - vc !== 0) begin
            n_fail++;
            $display("FAIL timeout: got err=%0d valid=%0d want err=1 valid=0",
                     err_cnt - ec, valid_cnt - vc);
        end
        send_packet(8'h1B, 8'h80, 8'h7F, 8'h09, "after_timeout");
    endtask

    task automatic test_reset_mid_packet();
        send_packet(8'h0F, 8'h03, 8'h04, 8'h06, "pre_reset");
        send_byte(8'h09, 1'b0, 1'b0);
        send_byte(8'h44, 1'b0, 1'b0);
        @(negedge clk);
        arst_n = 1'b0;
        #20;
        n_checks++;
        if ({o_valid, o_mouse_dx, o_mouse_dy, o_is_mouse_dx_neg, o_is_mouse_dy_neg,
             o_buttons, o_err} !== 23'd0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs: got dx=%0d dy=%0d btn=%b want all 0",
                     o_mouse_dx, o_mouse_dy, o_buttons);
        end
        @(negedge clk);
        arst_n = 1'b1;
        repeat (5) @(posedge clk);
        send_packet(8'h2A, 8'h10, 8'hF0, 8'h0C, "after_mid_reset");
    endtask

    task automatic test_random();
        logic [7:0] p0, p1, p2, p3;
        for (int i = 0; i < 12; i++) begin
            p0 = 8'($urandom_range(0, 255)) | 8'h08;
            p1 = 8'($urandom_range(0, 255));
            p2 = 8'($urandom_range(0, 255));
            p3 = 8'($urandom_range(0, 255));
            send_packet(p0, p1, p2, p3, $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_known_packets();
        test_bad_parity();
        test_bad_stop();
        test_resync();
        test_timeout();
        test_reset_mid_packet();
        test_random();
        repeat (5) @(posedge clk);
        n_checks++;
        if (idle_bad !== 0) begin
            n_fail++;
            $display("FAIL deltas_outside_valid: got %0d cycles want 0", idle_bad);
        end
        n_checks++;
        if (both_bad !== 0) begin
            n_fail++;
            $display("FAIL err_with_valid: got %0d cycles want 0", both_bad);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
